// File: rtl/braille_entry_encoder.sv
// Braille entry encoder: synchronises six dot switches and the ENTER button,
// debounces ENTER, and decodes the captured cell into a letter code A..P.
// Each press produces exactly one strobe: valid for a table hit, err for a miss.
module braille_entry_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] dots,
  input  logic       enter,
  output logic [3:0] playeralph,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reset-release qualifier: the input synchronisers start sampling only
  // after two edges following rst release.
  logic [1:0]       arm_q, arm_d;

  logic             enter_meta_q, enter_meta_d;
  logic             enter_s_q, enter_s_d;
  logic [5:0]       dots_meta_q, dots_meta_d;
  logic [5:0]       dots_s_q, dots_s_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       playeralph_q, playeralph_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [4:0]       dec;

  // Map a dot pattern to {hit, code}; any pattern not in A..P is a miss.
  function automatic logic [4:0] decode(input logic [5:0] d);
    logic [4:0] r;
    case (d)
      6'h01:   r = {1'b1, 4'd0};
      6'h03:   r = {1'b1, 4'd1};
      6'h09:   r = {1'b1, 4'd2};
      6'h19:   r = {1'b1, 4'd3};
      6'h11:   r = {1'b1, 4'd4};
      6'h0B:   r = {1'b1, 4'd5};
      6'h1B:   r = {1'b1, 4'd6};
      6'h13:   r = {1'b1, 4'd7};
      6'h0A:   r = {1'b1, 4'd8};
      6'h1A:   r = {1'b1, 4'd9};
      6'h05:   r = {1'b1, 4'd10};
      6'h07:   r = {1'b1, 4'd11};
      6'h0D:   r = {1'b1, 4'd12};
      6'h1D:   r = {1'b1, 4'd13};
      6'h15:   r = {1'b1, 4'd14};
      6'h0F:   r = {1'b1, 4'd15};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign dec = decode(dots_s_q);

  // Input synchroniser next-state: two flops per input, held clear until armed.
  always_comb begin
    arm_d        = {arm_q[0], 1'b1};
    enter_meta_d = arm_q[1] ? enter : enter_meta_q;
    dots_meta_d  = arm_q[1] ? dots  : dots_meta_q;
    enter_s_d    = enter_meta_q;
    dots_s_d     = dots_meta_q;
  end

  // Debounce FSM next-state and registered output computation.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    playeralph_d = playeralph_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_s_q) begin
          state_d = DB_PRESS;
          count_d = CNT_W'(1);
        end
      end
      DB_PRESS: begin
        if (!enter_s_q) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          if (dec[4]) begin
            playeralph_d = dec[3:0];
            valid_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = WAIT_RELEASE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (enter_s_q) begin
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q        <= '0;
      enter_meta_q <= 1'b0;
      enter_s_q    <= 1'b0;
      dots_meta_q  <= '0;
      dots_s_q     <= '0;
      state_q      <= IDLE;
      count_q      <= '0;
      playeralph_q <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      arm_q        <= arm_d;
      enter_meta_q <= enter_meta_d;
      enter_s_q    <= enter_s_d;
      dots_meta_q  <= dots_meta_d;
      dots_s_q     <= dots_s_d;
      state_q      <= state_d;
      count_q      <= count_d;
      playeralph_q <= playeralph_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign playeralph = playeralph_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule
